// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequences one matrix pass through an ARRAY_N x ARRAY_N
// systolic array: accumulator clear, skewed operand feed, flush, row drain.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start, k_len      pass request and inner length (sampled in IDLE)
//   abort             synchronous abort of the running pass
//   drain_ready       downstream accepts the current drain row
//   busy, done        pass in progress / 1-cycle completion pulse
//   acc_clear         1-cycle pulse zeroing PE accumulators
//   row_en, feed_idx  per-row feed enables and operand buffer index
//   drain_valid/row   result row handshake and row index
//   perf_cycles       busy-cycle counter (only with SEQ_PERF_CNT_EN)
//
// Optional feature macro: SEQ_PERF_CNT_EN adds the perf_cycles output.

module systolic_seq_ctrl #(
    parameter  int ARRAY_N = 4,
    parameter  int K_MAX   = 32,
    localparam int KW      = $clog2(K_MAX + 1),
    localparam int IW      = $clog2(K_MAX + ARRAY_N),
    localparam int RW      = $clog2(ARRAY_N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KW-1:0]      k_len,
    input  logic               abort,
    input  logic               drain_ready,
    output logic               busy,
    output logic               done,
    output logic               acc_clear,
    output logic [ARRAY_N-1:0] row_en,
    output logic [IW-1:0]      feed_idx,
    output logic               drain_valid,
    output logic [RW-1:0]      drain_row
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [RW-1:0]   r_flush;

    logic [KW-1:0]   w_k_clamp;
    logic [IW-1:0]   w_feed_nxt;
    logic            w_feed_last;
    logic            w_take;

    // Row i sees its operands i cycles late: that lag is the diagonal skew.
    function automatic logic [ARRAY_N-1:0] f_mask(
        input logic [IW-1:0] idx,
        input logic [KW-1:0] k
    );
        logic [ARRAY_N-1:0] m;
        m = '0;
        for (int i = 0; i < ARRAY_N; i++) begin
            m[i] = (int'(idx) >= i) && (int'(idx) < i + int'(k));
        end
        return m;
    endfunction

    assign w_k_clamp   = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign w_feed_nxt  = feed_idx + IW'(1);
    assign w_feed_last = (int'(feed_idx) == int'(r_k) + ARRAY_N - 2);
    assign w_take      = (r_state == S_IDLE) && start && !abort;

    // Outputs are registered alongside the state, so each one is
    // assigned for the state being entered rather than the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_flush     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            acc_clear   <= 1'b0;
            row_en      <= '0;
            feed_idx    <= '0;
            drain_valid <= 1'b0;
            drain_row   <= '0;
        end else if (abort && r_state != S_IDLE) begin
            r_state     <= S_IDLE;
            r_flush     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            acc_clear   <= 1'b0;
            row_en      <= '0;
            feed_idx    <= '0;
            drain_valid <= 1'b0;
            drain_row   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_k      <= w_k_clamp;
                        busy     <= 1'b1;
                        feed_idx <= '0;
                        if (w_k_clamp == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state   <= S_CLEAR;
                            acc_clear <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_state   <= S_FEED;
                    acc_clear <= 1'b0;
                    feed_idx  <= '0;
                    row_en    <= f_mask('0, r_k);
                end
                S_FEED: begin
                    if (w_feed_last) begin
                        r_state  <= S_FLUSH;
                        row_en   <= '0;
                        feed_idx <= '0;
                        r_flush  <= '0;
                    end else begin
                        feed_idx <= w_feed_nxt;
                        row_en   <= f_mask(w_feed_nxt, r_k);
                    end
                end
                S_FLUSH: begin
                    if (r_flush == RW'(ARRAY_N - 1)) begin
                        r_state     <= S_DRAIN;
                        r_flush     <= '0;
                        drain_valid <= 1'b1;
                        drain_row   <= '0;
                    end else begin
                        r_flush <= r_flush + RW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_ready) begin
                        if (drain_row == RW'(ARRAY_N - 1)) begin
                            r_state     <= S_DONE;
                            drain_valid <= 1'b0;
                            drain_row   <= '0;
                            done        <= 1'b1;
                        end else begin
                            drain_row <= drain_row + RW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_perf;

    // Counts every cycle busy is high, so an aborted pass keeps the
    // count it had through the abort cycle and then holds in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf <= '0;
        end else if (w_take) begin
            r_perf <= '0;
        end else if (busy && r_perf != '1) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: self-checking bench for systolic_seq_ctrl
// (ARRAY_N=4, K_MAX=32), table vectors plus randomized passes.

module tb_systolic_seq_ctrl;

    localparam int N  = 4;
    localparam int KM = 32;
    localparam int KW = $clog2(KM + 1);
    localparam int IW = $clog2(KM + N);
    localparam int RW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          abort = 1'b0;
    logic          drain_ready = 1'b1;
    logic          busy, done, acc_clear, drain_valid;
    logic [N-1:0]  row_en;
    logic [IW-1:0] feed_idx;
    logic [RW-1:0] drain_row;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]   perf_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.ARRAY_N(N), .K_MAX(KM)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .abort       (abort),
        .drain_ready (drain_ready),
        .busy        (busy),
        .done        (done),
        .acc_clear   (acc_clear),
        .row_en      (row_en),
        .feed_idx    (feed_idx),
        .drain_valid (drain_valid),
        .drain_row   (drain_row)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          clr;
        logic [N-1:0]  en;
        logic [IW-1:0] idx;
        logic          dv;
        logic [RW-1:0] row;
    } obs_t;

    typedef struct {
        int klen;
        int srow;
        int slen;
        int abort_cyc;
        int restart_cyc;
        int exp_done;
    } vec_t;

    vec_t vec[11];

    function automatic obs_t sample();
        obs_t o;
        o.busy = busy;
        o.done = done;
        o.clr  = acc_clear;
        o.en   = row_en;
        o.idx  = feed_idx;
        o.dv   = drain_valid;
        o.row  = drain_row;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Expected outputs come from the pass timeline: clear at cycle 1,
    // feed for K+N-1 cycles, flush N cycles, then drain until N rows
    // have been accepted, then one done cycle.
    task automatic run_pass(input int klen, input int srow, input int slen,
                            input int stall_pct, input int abort_cyc,
                            input int restart_cyc, input bit rand_start,
                            output int done_cyc);
        int   k, f, xfers, stalled, perf_exp;
        bit   post, in_feed;
        obs_t e, a;
        k        = (klen > KM) ? KM : klen;
        xfers    = 0;
        stalled  = 0;
        perf_exp = 0;
        post     = 1'b0;
        done_cyc = -1;
        start       = 1'b1;
        k_len       = KW'(klen);
        abort       = 1'b0;
        drain_ready = 1'b1;
        @(negedge clk);
        for (int t = 1; t <= 3000; t++) begin
            e       = '0;
            in_feed = 1'b0;
            a       = sample();
            if (!post) begin
                if (k == 0) begin
                    e.busy = 1'b1;
                    e.done = 1'b1;
                end else if (t == 1) begin
                    e.busy = 1'b1;
                    e.clr  = 1'b1;
                end else if (t <= k + N) begin
                    e.busy  = 1'b1;
                    in_feed = 1'b1;
                    f       = t - 2;
                    e.idx   = IW'(f);
                    for (int i = 0; i < N; i++)
                        e.en[i] = (f >= i) && (f < i + k);
                end else if (t <= k + 2 * N) begin
                    e.busy = 1'b1;
                end else if (xfers < N) begin
                    e.busy = 1'b1;
                    e.dv   = 1'b1;
                    e.row  = RW'(xfers);
                end else begin
                    e.busy = 1'b1;
                    e.done = 1'b1;
                end
            end
            if (!in_feed) a.idx = '0;
            chk($sformatf("k%0d_cyc%0d", klen, t), 32'(a), 32'(e));
`ifdef SEQ_PERF_CNT_EN
            if (t == 1) chk("perf_clear", perf_cycles, 32'd0);
`endif
            if (post) begin
                start       = 1'b0;
                abort       = 1'b0;
                drain_ready = 1'b1;
`ifdef SEQ_PERF_CNT_EN
                chk("perf_total", perf_cycles, 32'(perf_exp));
`endif
                return;
            end
            start = (t == restart_cyc) ||
                    (rand_start && $urandom_range(0, 4) == 0);
            abort = (t == abort_cyc);
            if (slen > 0) begin
                drain_ready = !(e.dv && xfers == srow && stalled < slen);
                if (!drain_ready) stalled++;
            end else begin
                drain_ready = ($urandom_range(0, 99) >= stall_pct);
            end
            if (e.busy) perf_exp++;
            if (e.dv && drain_ready) xfers++;
            if (e.done) begin
                done_cyc = t;
                post     = 1'b1;
            end
            if (abort) post = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL timeout k=%0d got=no_end want=end", klen);
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int   dc;
        int   kl, sp, ac;
        obs_t z;
        z = '0;

        vec[0]  = '{8, 0, 0, 0, 0, 21};
        vec[1]  = '{8, 1, 3, 0, 0, 24};
        vec[2]  = '{0, 0, 0, 0, 0, 1};
        vec[3]  = '{40, 0, 0, 0, 10, 45};
        vec[4]  = '{8, 0, 0, 7, 0, -1};
        vec[5]  = '{1, 0, 0, 0, 0, 14};
        vec[6]  = '{32, 0, 0, 0, 3, 45};
        vec[7]  = '{2, 0, 0, 1, 0, -1};
        vec[8]  = '{3, 3, 2, 0, 0, 18};
        vec[9]  = '{5, 0, 0, 15, 0, -1};
        vec[10] = '{63, 0, 0, 0, 40, 45};

        #2 rst = 1'b1;
        @(negedge clk);
        chk("reset_state", 32'(sample()), 32'(z));
`ifdef SEQ_PERF_CNT_EN
        chk("reset_perf", perf_cycles, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            run_pass(vec[v].klen, vec[v].srow, vec[v].slen, 0,
                     vec[v].abort_cyc, vec[v].restart_cyc, 1'b0, dc);
            chk($sformatf("done_cyc_v%0d", v), 32'(dc), 32'(vec[v].exp_done));
        end

        start = 1'b1;
        abort = 1'b1;
        k_len = KW'(5);
        @(negedge clk);
        chk("abort_start_idle", 32'(sample()), 32'(z));
        start = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(sample()), 32'(z));
        abort = 1'b0;

        start = 1'b1;
        k_len = KW'(2);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (drain_valid) break;
            @(negedge clk);
        end
        chk("reach_drain", 32'(drain_valid), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_async", 32'(sample()), 32'(z));
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hold", 32'(sample()), 32'(z));
        @(negedge clk);
        chk("no_done_after_rst", 32'(sample()), 32'(z));

        for (int r = 0; r < 150; r++) begin
            kl = $urandom_range(0, 63);
            sp = $urandom_range(0, 60);
            ac = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 50) : 0;
            run_pass(kl, 0, 0, sp, ac, 0, 1'b1, dc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
